// File: rtl/isa_mc.sv
// Multi-cycle architectural reference model: load port, start/halt control,
// configurable-latency multiplier and a registered per-instruction commit trace.
module isa_mc #(
    parameter int REG_LEN   = 8,
    parameter int RF_SIZE   = 4,
    parameter int MEMI_SIZE = 8,
    parameter int MEMD_SIZE = 4,
    parameter int MUL_LAT   = 3,
    localparam int RF_LOG   = $clog2(RF_SIZE),
    localparam int MEMI_LOG = $clog2(MEMI_SIZE),
    localparam int MEMD_LOG = $clog2(MEMD_SIZE),
    localparam int INST_LEN = 3 + REG_LEN + 2 * RF_LOG
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                load_en_i,
    input  logic                load_sel_i,
    input  logic [MEMI_LOG-1:0] load_addr_i,
    input  logic [INST_LEN-1:0] load_data_i,
    input  logic                start_i,
    output logic                busy_o,
    output logic                halted_o,
    output logic                commit_valid_o,
    output logic [MEMI_LOG-1:0] commit_pc_o,
    output logic                commit_wen_o,
    output logic [RF_LOG-1:0]   commit_rd_o,
    output logic [REG_LEN-1:0]  commit_data_o,
    output logic [1:0]          state_o
);

    localparam int CNT_W = $clog2(MUL_LAT + 1);

    localparam logic [2:0] OP_LI   = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_LD   = 3'd3;
    localparam logic [2:0] OP_BR   = 3'd4;
    localparam logic [2:0] OP_ST   = 3'd5;
    localparam logic [2:0] OP_HALT = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_MULW   = 2'd2,
        S_HALTED = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [MEMI_LOG-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [REG_LEN-1:0]  mul_res_q, mul_res_d;
    logic [RF_LOG-1:0]   mul_rd_q, mul_rd_d;

    logic [REG_LEN-1:0]  rf_q   [RF_SIZE];
    logic [INST_LEN-1:0] memi_q [MEMI_SIZE];
    logic [REG_LEN-1:0]  memd_q [MEMD_SIZE];

    // Commit trace is a valid-only stream: commit_valid_o pulses for one
    // cycle per retired instruction; there is no ready, the consumer must
    // sample every cycle.
    logic                commit_valid_q, commit_valid_d;
    logic [MEMI_LOG-1:0] commit_pc_q, commit_pc_d;
    logic                commit_wen_q, commit_wen_d;
    logic [RF_LOG-1:0]   commit_rd_q, commit_rd_d;
    logic [REG_LEN-1:0]  commit_data_q, commit_data_d;

    logic                rf_we;
    logic [RF_LOG-1:0]   rf_waddr;
    logic [REG_LEN-1:0]  rf_wdata;
    logic                memi_we;
    logic                memd_we;
    logic [MEMD_LOG-1:0] memd_waddr;
    logic [REG_LEN-1:0]  memd_wdata;

    logic [INST_LEN-1:0] inst;
    logic [2:0]          op;
    logic [REG_LEN-1:0]  imm;
    logic [RF_LOG-1:0]   rs1, rs2, rd;
    logic [REG_LEN-1:0]  rs1_val, rs2_val, ld_val, sum, prod;

    assign inst    = memi_q[pc_q];
    assign op      = inst[INST_LEN-1 -: 3];
    assign imm     = inst[2*RF_LOG +: REG_LEN];
    assign rs2     = inst[RF_LOG +: RF_LOG];
    assign rd      = inst[RF_LOG-1:0];
    assign rs1     = imm[RF_LOG-1:0];
    assign rs1_val = rf_q[rs1];
    assign rs2_val = rf_q[rs2];
    assign ld_val  = memd_q[rs1_val[MEMD_LOG-1:0]];
    assign sum     = rs1_val + rs2_val;
    assign prod    = rs1_val * rs2_val;

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        cnt_d          = cnt_q;
        mul_res_d      = mul_res_q;
        mul_rd_d       = mul_rd_q;
        rf_we          = 1'b0;
        rf_waddr       = rd;
        rf_wdata       = '0;
        memi_we        = 1'b0;
        memd_we        = 1'b0;
        memd_waddr     = load_addr_i[MEMD_LOG-1:0];
        memd_wdata     = load_data_i[REG_LEN-1:0];
        commit_valid_d = 1'b0;
        commit_pc_d    = '0;
        commit_wen_d   = 1'b0;
        commit_rd_d    = '0;
        commit_data_d  = '0;

        case (state_q)
            S_IDLE, S_HALTED: begin
                if (load_en_i) begin
                    memi_we = ~load_sel_i;
                    memd_we = load_sel_i;
                end
                if (start_i) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                end
            end
            S_RUN: begin
                commit_valid_d = 1'b1;
                commit_pc_d    = pc_q;
                pc_d           = pc_q + MEMI_LOG'(1);
                case (op)
                    OP_LI: begin
                        rf_we    = 1'b1;
                        rf_wdata = imm;
                    end
                    OP_ADD: begin
                        rf_we    = 1'b1;
                        rf_wdata = sum;
                    end
                    OP_MUL: begin
                        if (MUL_LAT == 1) begin
                            rf_we    = 1'b1;
                            rf_wdata = prod;
                        end else begin
                            // Operands are captured now; pc and rf hold until the count expires.
                            state_d        = S_MULW;
                            cnt_d          = CNT_W'(MUL_LAT - 1);
                            mul_res_d      = prod;
                            mul_rd_d       = rd;
                            pc_d           = pc_q;
                            commit_valid_d = 1'b0;
                            commit_pc_d    = '0;
                        end
                    end
                    OP_LD: begin
                        rf_we    = 1'b1;
                        rf_wdata = ld_val;
                    end
                    OP_BR: begin
                        if (rs2_val == '0) pc_d = pc_q + imm[MEMI_LOG-1:0];
                    end
                    OP_ST: begin
                        memd_we       = 1'b1;
                        memd_waddr    = rs1_val[MEMD_LOG-1:0];
                        memd_wdata    = rs2_val;
                        commit_data_d = rs2_val;
                    end
                    OP_HALT: begin
                        state_d = S_HALTED;
                        pc_d    = pc_q;
                    end
                    default: ;
                endcase
            end
            S_MULW: begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d          = '0;
                    rf_we          = 1'b1;
                    rf_waddr       = mul_rd_q;
                    rf_wdata       = mul_res_q;
                    pc_d           = pc_q + MEMI_LOG'(1);
                    state_d        = S_RUN;
                    commit_valid_d = 1'b1;
                    commit_pc_d    = pc_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (rf_we) begin
            commit_wen_d  = 1'b1;
            commit_rd_d   = rf_waddr;
            commit_data_d = rf_wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= S_IDLE;
            pc_q           <= '0;
            cnt_q          <= '0;
            mul_res_q      <= '0;
            mul_rd_q       <= '0;
            commit_valid_q <= 1'b0;
            commit_pc_q    <= '0;
            commit_wen_q   <= 1'b0;
            commit_rd_q    <= '0;
            commit_data_q  <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            cnt_q          <= cnt_d;
            mul_res_q      <= mul_res_d;
            mul_rd_q       <= mul_rd_d;
            commit_valid_q <= commit_valid_d;
            commit_pc_q    <= commit_pc_d;
            commit_wen_q   <= commit_wen_d;
            commit_rd_q    <= commit_rd_d;
            commit_data_q  <= commit_data_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < RF_SIZE; i++) rf_q[i] <= '0;
            for (int i = 0; i < MEMI_SIZE; i++) memi_q[i] <= '0;
            for (int i = 0; i < MEMD_SIZE; i++) memd_q[i] <= '0;
        end else begin
            if (rf_we) rf_q[rf_waddr] <= rf_wdata;
            if (memi_we) memi_q[load_addr_i] <= load_data_i;
            if (memd_we) memd_q[memd_waddr] <= memd_wdata;
        end
    end

    assign busy_o         = (state_q == S_RUN) || (state_q == S_MULW);
    assign halted_o       = (state_q == S_HALTED);
    assign commit_valid_o = commit_valid_q;
    assign commit_pc_o    = commit_pc_q;
    assign commit_wen_o   = commit_wen_q;
    assign commit_rd_o    = commit_rd_q;
    assign commit_data_o  = commit_data_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_isa_mc.sv
// Directed bench for isa_mc: hand-encoded programs, expected commit queue,
// explicit checks on reset, latency and boundary behaviour.
module tb_isa_mc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_en = 1'b0;
    logic        load_sel = 1'b0;
    logic [2:0]  load_addr = '0;
    logic [14:0] load_data = '0;
    logic        start = 1'b0;
    logic        busy, halted, commit_valid, commit_wen;
    logic [2:0]  commit_pc;
    logic [1:0]  commit_rd;
    logic [7:0]  commit_data;
    logic [1:0]  state;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [13:0] exp_q[$];
    int          cyc_q[$];

    isa_mc dut (
        .clk_i(clk), .rst_ni(rst_n), .load_en_i(load_en), .load_sel_i(load_sel),
        .load_addr_i(load_addr), .load_data_i(load_data), .start_i(start),
        .busy_o(busy), .halted_o(halted), .commit_valid_o(commit_valid),
        .commit_pc_o(commit_pc), .commit_wen_o(commit_wen), .commit_rd_o(commit_rd),
        .commit_data_o(commit_data), .state_o(state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [14:0] enc(input logic [2:0] op, input logic [7:0] imm,
                                        input logic [1:0] rs2, input logic [1:0] rd);
        return {op, imm, rs2, rd};
    endfunction

    function automatic logic [13:0] cm(input logic [2:0] pc, input logic wen,
                                       input logic [1:0] rd, input logic [7:0] data);
        return {pc, wen, rd, data};
    endfunction

    // Scoreboard: every commit is matched against the head of exp_q.
    always @(negedge clk) begin
        if (rst_n && commit_valid) begin
            cyc_q.push_back(cyc);
            if (exp_q.size() == 0) check("spurious_commit", {31'd0, commit_valid}, 32'd0);
            else check("commit", {18'd0, commit_pc, commit_wen, commit_rd, commit_data},
                       {18'd0, exp_q.pop_front()});
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        cyc_q.delete();
    endtask

    task automatic load_word(input logic sel, input logic [2:0] addr, input logic [14:0] data);
        load_en = 1'b1; load_sel = sel; load_addr = addr; load_data = data;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_halt(input int budget);
        for (int i = 0; i < budget && !halted; i++) @(negedge clk);
        #1;
        check("halt_reached", {31'd0, halted}, 32'd1);
        check("commits_left", exp_q.size(), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_halted"}, {31'd0, halted}, 32'd0);
        check({tag, "_cvalid"}, {31'd0, commit_valid}, 32'd0);
        check({tag, "_cpc"}, {29'd0, commit_pc}, 32'd0);
        check({tag, "_cwen"}, {31'd0, commit_wen}, 32'd0);
        check({tag, "_crd"}, {30'd0, commit_rd}, 32'd0);
        check({tag, "_cdata"}, {24'd0, commit_data}, 32'd0);
        check({tag, "_state"}, {30'd0, state}, 32'd0);
    endtask

    task automatic load_mul_prog();
        load_word(1'b0, 3'd0, enc(3'd0, 8'd5, 2'd0, 2'd1));
        load_word(1'b0, 3'd1, enc(3'd0, 8'd3, 2'd0, 2'd2));
        load_word(1'b0, 3'd2, enc(3'd2, 8'd1, 2'd2, 2'd3));
        load_word(1'b0, 3'd3, enc(3'd6, 8'd0, 2'd0, 2'd0));
    endtask

    initial begin
        int i;
        @(negedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;

        // LI/LI/MUL/HALT with MUL latency measured between commits
        do_reset();
        load_mul_prog();
        exp_q.push_back(cm(3'd0, 1'b1, 2'd1, 8'd5));
        exp_q.push_back(cm(3'd1, 1'b1, 2'd2, 8'd3));
        exp_q.push_back(cm(3'd2, 1'b1, 2'd3, 8'd15));
        exp_q.push_back(cm(3'd3, 1'b0, 2'd0, 8'd0));
        pulse_start();
        wait_halt(40);
        check("mul_latency", (cyc_q.size() >= 3) ? cyc_q[2] - cyc_q[1] : 0, 32'd3);
        check("halt_busy", {31'd0, busy}, 32'd0);

        // Reset asserted during MULW abandons the multiply
        do_reset();
        load_mul_prog();
        exp_q.push_back(cm(3'd0, 1'b1, 2'd1, 8'd5));
        exp_q.push_back(cm(3'd1, 1'b1, 2'd2, 8'd3));
        pulse_start();
        for (i = 0; i < 20 && state != 2'd2; i++) @(negedge clk);
        check("mulw_reached", {30'd0, state}, 32'd2);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midmul");
        @(negedge clk);
        rst_n = 1'b1;
        check("midmul_pending", exp_q.size(), 32'd0);
        load_word(1'b0, 3'd0, enc(3'd1, 8'd3, 2'd3, 2'd0));
        load_word(1'b0, 3'd1, enc(3'd6, 8'd0, 2'd0, 2'd0));
        exp_q.push_back(cm(3'd0, 1'b1, 2'd0, 8'd0));
        exp_q.push_back(cm(3'd1, 1'b0, 2'd0, 8'd0));
        pulse_start();
        wait_halt(20);

        // LD / ST / LD through data memory
        do_reset();
        load_word(1'b1, 3'd2, 15'd9);
        load_word(1'b0, 3'd0, enc(3'd0, 8'd2, 2'd0, 2'd1));
        load_word(1'b0, 3'd1, enc(3'd3, 8'd1, 2'd0, 2'd0));
        load_word(1'b0, 3'd2, enc(3'd0, 8'd3, 2'd0, 2'd3));
        load_word(1'b0, 3'd3, enc(3'd5, 8'd3, 2'd0, 2'd0));
        load_word(1'b0, 3'd4, enc(3'd3, 8'd3, 2'd0, 2'd2));
        load_word(1'b0, 3'd5, enc(3'd6, 8'd0, 2'd0, 2'd0));
        exp_q.push_back(cm(3'd0, 1'b1, 2'd1, 8'd2));
        exp_q.push_back(cm(3'd1, 1'b1, 2'd0, 8'd9));
        exp_q.push_back(cm(3'd2, 1'b1, 2'd3, 8'd3));
        exp_q.push_back(cm(3'd3, 1'b0, 2'd0, 8'd9));
        exp_q.push_back(cm(3'd4, 1'b1, 2'd2, 8'd9));
        exp_q.push_back(cm(3'd5, 1'b0, 2'd0, 8'd0));
        pulse_start();
        wait_halt(40);

        // Taken branch at pc 5 wraps to pc 3
        do_reset();
        load_word(1'b0, 3'd0, enc(3'd4, 8'd5, 2'd0, 2'd0));
        load_word(1'b0, 3'd5, enc(3'd4, 8'd6, 2'd0, 2'd0));
        load_word(1'b0, 3'd3, enc(3'd6, 8'd0, 2'd0, 2'd0));
        exp_q.push_back(cm(3'd0, 1'b0, 2'd0, 8'd0));
        exp_q.push_back(cm(3'd5, 1'b0, 2'd0, 8'd0));
        exp_q.push_back(cm(3'd3, 1'b0, 2'd0, 8'd0));
        pulse_start();
        wait_halt(20);

        // Not-taken branch at pc 5 falls through to pc 6
        do_reset();
        load_word(1'b0, 3'd0, enc(3'd0, 8'd1, 2'd0, 2'd1));
        load_word(1'b0, 3'd1, enc(3'd4, 8'd4, 2'd0, 2'd0));
        load_word(1'b0, 3'd5, enc(3'd4, 8'd6, 2'd1, 2'd0));
        load_word(1'b0, 3'd6, enc(3'd6, 8'd0, 2'd0, 2'd0));
        exp_q.push_back(cm(3'd0, 1'b1, 2'd1, 8'd1));
        exp_q.push_back(cm(3'd1, 1'b0, 2'd0, 8'd0));
        exp_q.push_back(cm(3'd5, 1'b0, 2'd0, 8'd0));
        exp_q.push_back(cm(3'd6, 1'b0, 2'd0, 8'd0));
        pulse_start();
        wait_halt(20);

        // Loads while running are ignored
        do_reset();
        load_word(1'b0, 3'd0, enc(3'd0, 8'd7, 2'd0, 2'd1));
        load_word(1'b0, 3'd1, enc(3'd0, 8'd8, 2'd0, 2'd2));
        load_word(1'b0, 3'd2, enc(3'd6, 8'd0, 2'd0, 2'd0));
        exp_q.push_back(cm(3'd0, 1'b1, 2'd1, 8'd7));
        exp_q.push_back(cm(3'd1, 1'b1, 2'd2, 8'd8));
        exp_q.push_back(cm(3'd2, 1'b0, 2'd0, 8'd0));
        pulse_start();
        load_en = 1'b1; load_sel = 1'b0; load_addr = 3'd1;
        load_data = enc(3'd0, 8'd99, 2'd0, 2'd2);
        @(negedge clk);
        @(negedge clk);
        load_en = 1'b0;
        wait_halt(20);

        // Load and start in the same idle cycle: the loaded word runs first
        do_reset();
        load_word(1'b0, 3'd0, enc(3'd6, 8'd0, 2'd0, 2'd0));
        load_word(1'b0, 3'd1, enc(3'd6, 8'd0, 2'd0, 2'd0));
        exp_q.push_back(cm(3'd0, 1'b1, 2'd1, 8'h55));
        exp_q.push_back(cm(3'd1, 1'b0, 2'd0, 8'd0));
        load_en = 1'b1; load_sel = 1'b0; load_addr = 3'd0;
        load_data = enc(3'd0, 8'h55, 2'd0, 2'd1);
        start = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
        start = 1'b0;
        wait_halt(20);

        // ADD overflow, then restart from HALTED with rf preserved
        do_reset();
        load_word(1'b0, 3'd0, enc(3'd0, 8'd200, 2'd0, 2'd1));
        load_word(1'b0, 3'd1, enc(3'd0, 8'd100, 2'd0, 2'd2));
        load_word(1'b0, 3'd2, enc(3'd1, 8'd1, 2'd2, 2'd3));
        load_word(1'b0, 3'd3, enc(3'd6, 8'd0, 2'd0, 2'd0));
        exp_q.push_back(cm(3'd0, 1'b1, 2'd1, 8'd200));
        exp_q.push_back(cm(3'd1, 1'b1, 2'd2, 8'd100));
        exp_q.push_back(cm(3'd2, 1'b1, 2'd3, 8'd44));
        exp_q.push_back(cm(3'd3, 1'b0, 2'd0, 8'd0));
        pulse_start();
        wait_halt(20);
        @(negedge clk);
        load_word(1'b0, 3'd0, enc(3'd1, 8'd3, 2'd3, 2'd0));
        load_word(1'b0, 3'd1, enc(3'd6, 8'd0, 2'd0, 2'd0));
        exp_q.push_back(cm(3'd0, 1'b1, 2'd0, 8'd88));
        exp_q.push_back(cm(3'd1, 1'b0, 2'd0, 8'd0));
        pulse_start();
        wait_halt(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
